// File: rtl/pc_issue_unit.sv
// rtl/pc_issue_unit.sv - fetch PC register with valid/ready issue, commit gating and redirect
// Optional PC_ALIGN_CHK_EN traps misaligned targets into HALT instead of truncating them.
module pc_issue_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 32'h8000_0000,
  parameter int unsigned ILEN_BYTES = 4,
  parameter int unsigned MAX_INFLIGHT = 1,
  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  output logic                  pc_valid,
  input  logic                  pc_ready,
  output logic [DATA_WIDTH-1:0] pc,
  input  logic                  commit_valid,
  input  logic [DATA_WIDTH-1:0] commit_npc,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic [CNT_W-1:0]      inflight,
  output logic                  pc_fault
);

  localparam logic [DATA_WIDTH-1:0] LOW_MASK = DATA_WIDTH'(ILEN_BYTES - 1);
  localparam logic [DATA_WIDTH-1:0] ILEN_INC = DATA_WIDTH'(ILEN_BYTES);
  localparam logic [CNT_W-1:0]      MAX_CNT  = CNT_W'(MAX_INFLIGHT);

  typedef enum logic [1:0] {BOOT, ISSUE, WAIT, HALT} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  pc_valid_q, pc_valid_d;
  logic [CNT_W-1:0]      inflight_q, inflight_d;
  logic                  pc_fault_q, pc_fault_d;

  logic                  handshake;
  logic                  commit_take;
  logic [CNT_W-1:0]      cnt_after;
  logic                  redirect_bad;
  logic                  npc_bad;

`ifdef PC_ALIGN_CHK_EN
  assign redirect_bad = (redirect_pc & LOW_MASK) != '0;
  assign npc_bad      = (commit_npc & LOW_MASK) != '0;
`else
  assign redirect_bad = 1'b0;
  assign npc_bad      = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pc_valid_d  = pc_valid_q;
    inflight_d  = inflight_q;
    pc_fault_d  = pc_fault_q;
    handshake   = pc_valid_q & pc_ready;
    // A commit with nothing outstanding is dropped so the counter cannot underflow.
    commit_take = commit_valid && (inflight_q != '0) && (state_q != HALT);
    cnt_after   = inflight_q + CNT_W'(handshake) - CNT_W'(commit_take);

    if (redirect_valid) begin
      inflight_d = '0;
      if (redirect_bad) begin
        state_d    = HALT;
        pc_d       = redirect_pc;
        pc_valid_d = 1'b0;
        pc_fault_d = 1'b1;
      end else begin
        pc_d       = redirect_pc & ~LOW_MASK;
        pc_fault_d = 1'b0;
        pc_valid_d = !stall;
        state_d    = stall ? WAIT : ISSUE;
      end
    end else begin
      case (state_q)
        BOOT: begin
          if (!stall) begin
            state_d    = ISSUE;
            pc_valid_d = 1'b1;
          end
        end
        ISSUE: begin
          inflight_d = cnt_after;
          if (handshake) begin
            if (MAX_INFLIGHT == 1) begin
              state_d    = WAIT;
              pc_valid_d = 1'b0;
            end else begin
              pc_d = pc_q + ILEN_INC;
              if ((cnt_after == MAX_CNT) || stall) begin
                state_d    = WAIT;
                pc_valid_d = 1'b0;
              end
            end
          end
        end
        WAIT: begin
          inflight_d = cnt_after;
          if ((MAX_INFLIGHT == 1) && commit_take && npc_bad) begin
            state_d    = HALT;
            pc_d       = commit_npc;
            pc_valid_d = 1'b0;
            pc_fault_d = 1'b1;
          end else begin
            if ((MAX_INFLIGHT == 1) && commit_take) begin
              pc_d = commit_npc & ~LOW_MASK;
            end
            if (!stall && (cnt_after < MAX_CNT)) begin
              state_d    = ISSUE;
              pc_valid_d = 1'b1;
            end
          end
        end
        HALT: begin
          pc_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      pc_valid_q <= 1'b0;
      inflight_q <= '0;
      pc_fault_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      inflight_q <= inflight_d;
      pc_fault_q <= pc_fault_d;
    end
  end

  assign pc       = pc_q;
  assign pc_valid = pc_valid_q;
  assign inflight = inflight_q;
  assign pc_fault = pc_fault_q;

endmodule

// File: tb/tb_pc_issue_unit.sv
// tb/tb_pc_issue_unit.sv - directed and randomized checks of pc_issue_unit (commit-gated and prefetch builds)
module tb_pc_issue_unit;
  localparam logic [31:0] RV = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        pc_ready = 1'b0;
  logic        commit_valid = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] commit_npc = '0;
  logic [31:0] redirect_pc = '0;

  logic        v1, v4, f1, f4;
  logic [31:0] pc1, pc4;
  logic [0:0]  inf1;
  logic [2:0]  inf4;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  pc_issue_unit #(.MAX_INFLIGHT(1)) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .pc_valid(v1), .pc_ready(pc_ready), .pc(pc1),
    .commit_valid(commit_valid), .commit_npc(commit_npc), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .inflight(inf1), .pc_fault(f1)
  );

  pc_issue_unit #(.MAX_INFLIGHT(4)) dut4 (
    .clk(clk), .rst(rst), .stall(stall), .pc_valid(v4), .pc_ready(pc_ready), .pc(pc4),
    .commit_valid(commit_valid), .commit_npc(commit_npc), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .inflight(inf4), .pc_fault(f4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 1'b0; pc_ready = 1'b0; commit_valid = 1'b0; redirect_valid = 1'b0;
    commit_npc = '0; redirect_pc = '0;
  endtask

  task automatic hard_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    total_cnt++; if (pc4 !== RV) $display("FAIL reset_pc4: got %h want %h", pc4, RV); else pass_cnt++;
    total_cnt++; if (v4 !== 1'b0) $display("FAIL reset_valid4: got %b want 0", v4); else pass_cnt++;
    total_cnt++; if (inf4 !== 3'd0) $display("FAIL reset_inflight4: got %0d want 0", inf4); else pass_cnt++;
    total_cnt++; if (f4 !== 1'b0) $display("FAIL reset_fault4: got %b want 0", f4); else pass_cnt++;
    total_cnt++; if (v1 !== 1'b0 || pc1 !== RV) $display("FAIL reset_dut1: valid %b pc %h want 0 %h", v1, pc1, RV); else pass_cnt++;
    rst = 1'b0;
    step();
    total_cnt++; if (v4 !== 1'b1 || pc4 !== RV) $display("FAIL boot_issue4: valid %b pc %h want 1 %h", v4, pc4, RV); else pass_cnt++;
    total_cnt++; if (v1 !== 1'b1) $display("FAIL boot_issue1: valid %b want 1", v1); else pass_cnt++;
    pc_ready = 1'b1;
    step();
    step();
    total_cnt++; if (pc4 !== RV + 32'd8 || inf4 !== 3'd2) $display("FAIL pre_rst_issue: pc %h infl %0d want %h 2", pc4, inf4, RV + 32'd8); else pass_cnt++;
    #3;
    rst = 1'b1;
    #1;
    total_cnt++; if (pc4 !== RV || v4 !== 1'b0 || inf4 !== 3'd0) $display("FAIL async_rst: pc %h valid %b infl %0d want %h 0 0", pc4, v4, inf4, RV); else pass_cnt++;
    rst = 1'b0;
    pc_ready = 1'b0;
    step();
    total_cnt++; if (pc4 !== RV || v4 !== 1'b1) $display("FAIL post_rst_issue: pc %h valid %b want %h 1", pc4, v4, RV); else pass_cnt++;
  endtask

  task automatic test_commit_gated();
    hard_reset();
    pc_ready = 1'b1;
    step();
    total_cnt++; if (v1 !== 1'b1 || pc1 !== RV) $display("FAIL gated_offer: valid %b pc %h want 1 %h", v1, pc1, RV); else pass_cnt++;
    step();
    total_cnt++; if (v1 !== 1'b0 || inf1 !== 1'b1 || pc1 !== RV) $display("FAIL gated_wait: valid %b infl %0d pc %h want 0 1 %h", v1, inf1, pc1, RV); else pass_cnt++;
    commit_valid = 1'b1;
    commit_npc = 32'h8000_0010;
    step();
    commit_valid = 1'b0;
    total_cnt++; if (v1 !== 1'b1 || pc1 !== 32'h8000_0010 || inf1 !== 1'b0) $display("FAIL gated_reissue: valid %b pc %h infl %0d want 1 80000010 0", v1, pc1, inf1); else pass_cnt++;
  endtask

  task automatic test_prefetch();
    logic [31:0] issued[$];
    hard_reset();
    pc_ready = 1'b1;
    step();
    repeat (6) begin
      if (v4 && pc_ready) issued.push_back(pc4);
      step();
    end
    total_cnt++; if (issued.size() != 4) $display("FAIL prefetch_count: got %0d want 4", issued.size()); else pass_cnt++;
    for (int i = 0; i < issued.size() && i < 4; i++) begin
      total_cnt++;
      if (issued[i] !== RV + 32'(4 * i)) $display("FAIL prefetch_pc%0d: got %h want %h", i, issued[i], RV + 32'(4 * i)); else pass_cnt++;
    end
    total_cnt++; if (inf4 !== 3'd4 || v4 !== 1'b0 || pc4 !== RV + 32'h10) $display("FAIL prefetch_full: infl %0d valid %b pc %h want 4 0 %h", inf4, v4, pc4, RV + 32'h10); else pass_cnt++;
    commit_valid = 1'b1;
    step();
    commit_valid = 1'b0;
    total_cnt++; if (v4 !== 1'b1 || pc4 !== 32'h8000_0010 || inf4 !== 3'd3) $display("FAIL prefetch_resume: valid %b pc %h infl %0d want 1 80000010 3", v4, pc4, inf4); else pass_cnt++;
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0100;
    commit_valid = 1'b1;
    pc_ready = 1'b1;
    step();
    clear_inputs();
    total_cnt++; if (pc4 !== 32'h8000_0100 || inf4 !== 3'd0 || v4 !== 1'b1) $display("FAIL redirect_prio: pc %h infl %0d valid %b want 80000100 0 1", pc4, inf4, v4); else pass_cnt++;
  endtask

  task automatic test_hold();
    pc_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      stall = ~stall;
      step();
      total_cnt++;
      if (pc4 !== 32'h8000_0100 || v4 !== 1'b1 || pc1 !== 32'h8000_0100 || v1 !== 1'b1)
        $display("FAIL hold_cycle%0d: pc4 %h v4 %b pc1 %h v1 %b want 80000100 1", i, pc4, v4, pc1, v1);
      else pass_cnt++;
    end
    stall = 1'b0;
  endtask

  task automatic test_underflow();
    commit_valid = 1'b1;
    step();
    commit_valid = 1'b0;
    total_cnt++; if (inf4 !== 3'd0 || inf1 !== 1'b0 || v4 !== 1'b1) $display("FAIL underflow: infl4 %0d infl1 %0d v4 %b want 0 0 1", inf4, inf1, v4); else pass_cnt++;
  endtask

  task automatic test_misaligned();
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0102;
    step();
    clear_inputs();
`ifdef PC_ALIGN_CHK_EN
    total_cnt++; if (f4 !== 1'b1 || v4 !== 1'b0 || pc4 !== 32'h8000_0102) $display("FAIL misalign_trap: fault %b valid %b pc %h want 1 0 80000102", f4, v4, pc4); else pass_cnt++;
    commit_valid = 1'b1;
    step();
    commit_valid = 1'b0;
    total_cnt++; if (f4 !== 1'b1 || v4 !== 1'b0 || pc4 !== 32'h8000_0102) $display("FAIL halt_hold: fault %b valid %b pc %h want 1 0 80000102", f4, v4, pc4); else pass_cnt++;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0200;
    step();
    clear_inputs();
    total_cnt++; if (f4 !== 1'b0 || v4 !== 1'b1 || pc4 !== 32'h8000_0200) $display("FAIL halt_exit: fault %b valid %b pc %h want 0 1 80000200", f4, v4, pc4); else pass_cnt++;
`else
    total_cnt++; if (pc4 !== 32'h8000_0100 || v4 !== 1'b1 || f4 !== 1'b0) $display("FAIL misalign_trunc: pc %h valid %b fault %b want 80000100 1 0", pc4, v4, f4); else pass_cnt++;
    total_cnt++; if (pc1 !== 32'h8000_0100 || f1 !== 1'b0) $display("FAIL misalign_trunc1: pc %h fault %b want 80000100 0", pc1, f1); else pass_cnt++;
`endif
  endtask

  task automatic test_wrap_and_stall();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    clear_inputs();
    total_cnt++; if (pc4 !== 32'hFFFF_FFFC || v4 !== 1'b1) $display("FAIL wrap_load: pc %h valid %b want fffffffc 1", pc4, v4); else pass_cnt++;
    pc_ready = 1'b1;
    step();
    total_cnt++; if (pc4 !== 32'h0 || inf4 !== 3'd1 || v4 !== 1'b1) $display("FAIL wrap_inc: pc %h infl %0d valid %b want 0 1 1", pc4, inf4, v4); else pass_cnt++;
    stall = 1'b1;
    step();
    total_cnt++; if (pc4 !== 32'h4 || v4 !== 1'b0 || inf4 !== 3'd2) $display("FAIL stall_hs: pc %h valid %b infl %0d want 4 0 2", pc4, v4, inf4); else pass_cnt++;
    stall = 1'b0;
    pc_ready = 1'b0;
    step();
    total_cnt++; if (pc4 !== 32'h4 || v4 !== 1'b1 || inf4 !== 3'd2) $display("FAIL stall_release: pc %h valid %b infl %0d want 4 1 2", pc4, v4, inf4); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [31:0] m_pc;
    logic        m_off;
    logic        hs;
    logic [31:0] m_q[$];
    int          errs;
    hard_reset();
    m_pc = RV;
    m_off = 1'b0;
    errs = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      stall          = ($urandom_range(3) == 0);
      pc_ready       = 1'($urandom_range(1));
      commit_valid   = ($urandom_range(9) < 3);
      redirect_valid = ($urandom_range(19) == 0);
      redirect_pc    = $urandom();
`ifdef PC_ALIGN_CHK_EN
      redirect_pc    = redirect_pc & ~32'd3;
`endif
      commit_npc     = $urandom();
      if (redirect_valid) begin
        m_q.delete();
        m_pc  = redirect_pc & ~32'd3;
        m_off = !stall;
      end else begin
        hs = m_off && pc_ready;
        if (commit_valid && m_q.size() > 0) void'(m_q.pop_front());
        if (hs) begin
          m_q.push_back(m_pc);
          m_pc = m_pc + 32'd4;
          if (m_q.size() == 4 || stall) m_off = 1'b0;
        end else if (!m_off) begin
          m_off = !stall && (m_q.size() < 4);
        end
      end
      step();
      total_cnt++;
      if (pc4 !== m_pc || v4 !== m_off || inf4 !== 3'(m_q.size())) begin
        if (errs < 10) $display("FAIL random_cyc%0d: pc %h valid %b infl %0d want %h %b %0d", cyc, pc4, v4, inf4, m_pc, m_off, m_q.size());
        errs++;
      end else pass_cnt++;
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_commit_gated();
    test_prefetch();
    test_redirect();
    test_hold();
    test_underflow();
    test_misaligned();
    test_wrap_and_stall();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
